// File: rtl/uart_bus_bridge_pkg.sv
// Shared constants for the UART bus bridge: default register offsets,
// CON bit positions, TX state encoding and a CON word packing helper.
package uart_bridge_pkg;

  // Default byte-address offsets of the three registers
  localparam logic [7:0] DEF_ADDR_TXD = 8'h18;
  localparam logic [7:0] DEF_ADDR_RXD = 8'h1C;
  localparam logic [7:0] DEF_ADDR_CON = 8'h20;

  // CON register bit positions
  localparam int CON_TX_IRQ_EN = 0;
  localparam int CON_RX_IRQ_EN = 1;
  localparam int CON_TX_DONE   = 2;
  localparam int CON_RX_VALID  = 3;
  localparam int CON_FIFO_FULL = 4;
  localparam int CON_TX_IDLE   = 5;
  localparam int CON_TX_OVF    = 6;

  // TX sequencing state encoding
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;

  // Assemble the CON read word; unlisted bits read as zero
  function automatic logic [31:0] pack_con(
    input logic tx_irq_en,
    input logic rx_irq_en,
    input logic tx_done,
    input logic rx_valid,
    input logic fifo_full,
    input logic tx_idle,
    input logic tx_ovf
  );
    logic [31:0] v;
    v                = '0;
    v[CON_TX_IRQ_EN] = tx_irq_en;
    v[CON_RX_IRQ_EN] = rx_irq_en;
    v[CON_TX_DONE]   = tx_done;
    v[CON_RX_VALID]  = rx_valid;
    v[CON_FIFO_FULL] = fifo_full;
    v[CON_TX_IDLE]   = tx_idle;
    v[CON_TX_OVF]    = tx_ovf;
    return v;
  endfunction

endpackage

// File: rtl/uart_bus_bridge_if.sv
// Bundle of the data-memory bus signals and the UART parallel handshake.
// 'slave' is the bridge's view; 'master' is the environment driving the
// bus and playing the UART.
interface uart_bus_bridge_if;
  logic        rd;
  logic        wr;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;
  logic [7:0]  uart_rxd;
  logic        rx_eff;
  logic        rx_read;
  logic [7:0]  uart_txd;
  logic        tx_en;
  logic        tx_status;

  modport slave (
    input  rd, wr, addr, wdata, uart_rxd, rx_eff, tx_status,
    output rdata, irq, rx_read, uart_txd, tx_en
  );

  modport master (
    output rd, wr, addr, wdata, uart_rxd, rx_eff, tx_status,
    input  rdata, irq, rx_read, uart_txd, tx_en
  );
endinterface

// File: rtl/uart_bus_bridge_tx_fifo.sv
// Small synchronous byte FIFO for outgoing UART data. The head is presented
// combinationally so the TX sequencer can launch it in the same cycle it
// decides to pop. Pushes into a full FIFO and pops from an empty one are
// ignored.
module uart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       srst,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [7:0]  r_mem [DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic        w_do_push;
  logic        w_do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match
  assign empty     = (r_wptr == r_rptr);
  assign full      = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign dout      = r_mem[r_rptr[AW-1:0]];

  // Pointer update; push and pop in one cycle both advance
  always_ff @(posedge clk) begin
    if (srst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_do_pop)  r_rptr <= r_rptr + PTR_ONE;
    end
  end

  // Storage write; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_bus_bridge.sv
// CPU-side bridge to the UART peripheral: TXD/RXD/CON registers on the
// data-memory bus, a TX byte FIFO with a launch/handshake sequencer, a
// single-byte RX holding register and a level interrupt.
module uart_bus_bridge
  import uart_bridge_pkg::*;
#(
  parameter int         TX_DEPTH = 4,
  parameter logic [7:0] ADDR_TXD = DEF_ADDR_TXD,
  parameter logic [7:0] ADDR_RXD = DEF_ADDR_RXD,
  parameter logic [7:0] ADDR_CON = DEF_ADDR_CON
) (
  input  logic               sysclk,
  input  logic               reset,
  uart_bus_bridge_if.slave   bus
);

  logic [1:0]  r_state;
  logic        r_tx_en;
  logic [7:0]  r_uart_txd;
  logic        r_tx_done;
  logic        r_tx_ovf;
  logic [1:0]  r_irq_en;
  logic [7:0]  r_rx_hold;
  logic        r_rx_valid;
  logic        r_rx_read;

  logic        w_txd_wr;
  logic        w_con_wr;
  logic        w_rxd_rd;
  logic        w_con_rd;
  logic        w_fifo_full;
  logic        w_fifo_empty;
  logic [7:0]  w_fifo_head;
  logic        w_launch;
  logic        w_tx_done_set;
  logic        w_tx_ovf_set;
  logic        w_capture;
  logic        w_tx_idle;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_txd_wr = bus.wr && (bus.addr == ADDR_TXD);
  assign w_con_wr = bus.wr && (bus.addr == ADDR_CON);
  assign w_rxd_rd = bus.rd && (bus.addr == ADDR_RXD);
  assign w_con_rd = bus.rd && (bus.addr == ADDR_CON);

  // Only the low byte of TXD and the two enable bits of CON are writable
  assign w_unused = &{1'b0, bus.wdata[31:8]};

  // Launch the head byte once the UART reports its sender idle
  assign w_launch      = (r_state == ST_IDLE) && !w_fifo_empty && bus.tx_status;
  assign w_tx_done_set = (r_state == ST_WAIT_DONE) && bus.tx_status;
  assign w_tx_ovf_set  = w_txd_wr && w_fifo_full;
  assign w_tx_idle     = w_fifo_empty && (r_state == ST_IDLE);

  // The rx_read guard stops a second capture while the UART drops rx_eff;
  // a same-cycle RXD read also defers capture so the read byte is not lost
  assign w_capture = bus.rx_eff && !r_rx_valid && !r_rx_read && !w_rxd_rd;

  uart_tx_fifo #(
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk   (sysclk),
    .srst  (reset),
    .push  (w_txd_wr),
    .din   (bus.wdata[7:0]),
    .pop   (w_launch),
    .dout  (w_fifo_head),
    .full  (w_fifo_full),
    .empty (w_fifo_empty)
  );

  // TX sequencer: launch, wait for the UART to go busy, then for it to finish
  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_tx_en    <= 1'b0;
      r_uart_txd <= 8'h00;
    end else begin
      r_tx_en <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_launch) begin
            r_uart_txd <= w_fifo_head;
            r_tx_en    <= 1'b1;
            r_state    <= ST_WAIT_BUSY;
          end
        end
        ST_WAIT_BUSY: begin
          if (!bus.tx_status) r_state <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (bus.tx_status) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Sticky status flags; a set in the same cycle as a CON read wins
  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_tx_done <= 1'b0;
      r_tx_ovf  <= 1'b0;
    end else begin
      if (w_tx_done_set)  r_tx_done <= 1'b1;
      else if (w_con_rd)  r_tx_done <= 1'b0;
      if (w_tx_ovf_set)   r_tx_ovf  <= 1'b1;
      else if (w_con_rd)  r_tx_ovf  <= 1'b0;
    end
  end

  // Interrupt enable bits, the only writable part of CON
  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_irq_en <= 2'b00;
    end else if (w_con_wr) begin
      r_irq_en <= bus.wdata[1:0];
    end
  end

  // RX holding register: capture one byte, acknowledge with a rx_read pulse
  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_rx_hold  <= 8'h00;
      r_rx_valid <= 1'b0;
      r_rx_read  <= 1'b0;
    end else begin
      r_rx_read <= w_capture;
      if (w_capture) begin
        r_rx_hold  <= bus.uart_rxd;
        r_rx_valid <= 1'b1;
      end else if (w_rxd_rd) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  // Read mux; unmapped offsets return zero
  always_comb begin
    w_rdata = 32'h0;
    if (bus.rd) begin
      if (bus.addr == ADDR_RXD) begin
        w_rdata = {24'h0, r_rx_hold};
      end else if (bus.addr == ADDR_CON) begin
        w_rdata = pack_con(r_irq_en[CON_TX_IRQ_EN], r_irq_en[CON_RX_IRQ_EN],
                           r_tx_done, r_rx_valid, w_fifo_full, w_tx_idle, r_tx_ovf);
      end
    end
  end

  assign bus.rdata    = w_rdata;
  assign bus.irq      = (r_irq_en[CON_TX_IRQ_EN] & r_tx_done) |
                        (r_irq_en[CON_RX_IRQ_EN] & r_rx_valid);
  assign bus.tx_en    = r_tx_en;
  assign bus.uart_txd = r_uart_txd;
  assign bus.rx_read  = r_rx_read;

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Bench for uart_bus_bridge: a CPU-side bus driver plus simple UART models.
// Expected TX and RX bytes are queued when stimulus is issued and checked
// when the bridge launches a byte or returns one on an RXD read.
module tb_uart_bus_bridge;

  localparam logic [7:0] A_TXD = 8'h18;
  localparam logic [7:0] A_RXD = 8'h1C;
  localparam logic [7:0] A_CON = 8'h20;

  logic sysclk = 1'b0;
  logic reset;
  logic hold_busy = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int tx_count = 0;
  int rx_read_count = 0;
  int busy_cnt;

  byte unsigned tx_exp[$];
  byte unsigned rx_exp[$];
  byte unsigned rx_src[$];

  always #5 sysclk = ~sysclk;

  uart_bus_bridge_if bus();

  uart_bus_bridge dut (
    .sysclk (sysclk),
    .reset  (reset),
    .bus    (bus)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %h", tag, got);
    end
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    @(posedge sysclk); #1;
    bus.wr = 1'b1; bus.addr = a; bus.wdata = d;
    @(posedge sysclk); #1;
    bus.wr = 1'b0; bus.addr = 8'h00; bus.wdata = 32'h0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
    @(posedge sysclk); #1;
    bus.rd = 1'b1; bus.addr = a;
    #3 d = bus.rdata;
    @(posedge sysclk); #1;
    bus.rd = 1'b0; bus.addr = 8'h00;
  endtask

  // Back-to-back TXD writes of consecutive byte values
  task automatic burst_txd(input logic [7:0] first, input int n);
    @(posedge sysclk); #1;
    bus.wr = 1'b1; bus.addr = A_TXD;
    for (int i = 0; i < n; i++) begin
      bus.wdata = {24'h0, first + 8'(i)};
      @(posedge sysclk); #1;
    end
    bus.wr = 1'b0; bus.addr = 8'h00; bus.wdata = 32'h0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin @(posedge sysclk); #1; end
  endtask

  task automatic wait_tx_status_high(input string tag, input int limit);
    int i;
    i = 0;
    while (bus.tx_status !== 1'b1 && i < limit) begin
      @(posedge sysclk); #1; i++;
    end
    check_val(tag, {31'h0, bus.tx_status}, 32'h1);
  endtask

  task automatic wait_tx_drained(input string tag, input int limit);
    int i;
    i = 0;
    while (tx_exp.size() != 0 && i < limit) begin
      @(posedge sysclk); #1; i++;
    end
    check_val(tag, tx_exp.size(), 32'h0);
  endtask

  task automatic wait_irq(input string tag, input int limit);
    int i;
    i = 0;
    while (bus.irq !== 1'b1 && i < limit) begin
      @(posedge sysclk); #1; i++;
    end
    check_val(tag, {31'h0, bus.irq}, 32'h1);
  endtask

  // UART sender model: busy for 10 cycles after each tx_en, or held busy
  initial begin
    bus.tx_status = 1'b1;
    busy_cnt = 0;
    forever begin
      @(posedge sysclk); #1;
      if (bus.tx_en === 1'b1) begin
        tx_count++;
        if (tx_exp.size() == 0) check_val("tx_unexpected", tx_exp.size(), 32'h1);
        else check_val("tx_byte", {24'h0, bus.uart_txd}, {24'h0, tx_exp.pop_front()});
        busy_cnt = 10;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
      end
      bus.tx_status = (busy_cnt == 0) && !hold_busy;
    end
  end

  // UART receiver model: offers queued bytes, drops rx_eff after rx_read
  initial begin
    bus.rx_eff = 1'b0;
    bus.uart_rxd = 8'h00;
    forever begin
      @(posedge sysclk); #1;
      if (bus.rx_read === 1'b1) begin
        rx_read_count++;
        bus.rx_eff = 1'b0;
      end else if (!bus.rx_eff && rx_src.size() > 0) begin
        bus.uart_rxd = rx_src.pop_front();
        bus.rx_eff = 1'b1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int tc0;
    int rc0;

    reset = 1'b1;
    bus.rd = 1'b0; bus.wr = 1'b0; bus.addr = 8'h00; bus.wdata = 32'h0;
    repeat (3) @(posedge sysclk);
    #1 reset = 1'b0;

    // Reset state
    check_val("rst_irq", {31'h0, bus.irq}, 32'h0);
    check_val("rst_tx_en", {31'h0, bus.tx_en}, 32'h0);
    check_val("rst_rx_read", {31'h0, bus.rx_read}, 32'h0);
    check_val("rst_uart_txd", {24'h0, bus.uart_txd}, 32'h0);
    bus_read(A_CON, d);
    check_val("rst_con", d, 32'h20);

    // Single byte send, latency and tx_done stickiness
    tx_exp.push_back(8'hA5);
    bus_write(A_TXD, 32'h0000_00A5);
    check_val("tx_lat_k", {31'h0, bus.tx_en}, 32'h0);
    @(posedge sysclk); #1;
    check_val("tx_lat_k1", {31'h0, bus.tx_en}, 32'h1);
    check_val("tx_data_a5", {24'h0, bus.uart_txd}, 32'hA5);
    @(posedge sysclk); #1;
    check_val("tx_en_pulse", {31'h0, bus.tx_en}, 32'h0);
    wait_tx_status_high("tx1_wait", 40);
    wait_cycles(2);
    bus_read(A_CON, d);
    check_val("con_tx_done", d, 32'h24);
    bus_read(A_CON, d);
    check_val("con_tx_done_clr", d, 32'h20);
    check_val("tx_hold_a5", {24'h0, bus.uart_txd}, 32'hA5);

    // Overflow: five writes while the UART stays busy
    hold_busy = 1'b1;
    wait_cycles(2);
    for (int i = 0; i < 4; i++) tx_exp.push_back(8'(8'h11 + i));
    tc0 = tx_count;
    burst_txd(8'h11, 5);
    bus_read(A_CON, d);
    check_val("con_full_ovf", d, 32'h50);
    hold_busy = 1'b0;
    wait_tx_drained("ovf_drain", 200);
    wait_tx_status_high("ovf_last_wait", 40);
    wait_cycles(2);
    check_val("ovf_sent_count", tx_count - tc0, 32'd4);
    bus_read(A_CON, d);
    check_val("con_after_ovf", d, 32'h24);

    // Single received byte
    rc0 = rx_read_count;
    rx_exp.push_back(8'h3C);
    rx_src.push_back(8'h3C);
    wait_cycles(8);
    check_val("rx_read_once", rx_read_count - rc0, 32'd1);
    bus_read(A_CON, d);
    check_val("con_rx_valid", {31'h0, d[3]}, 32'h1);
    check_val("rx_irq_masked", {31'h0, bus.irq}, 32'h0);
    bus_read(A_RXD, d);
    check_val("rxd_3c", d, {24'h0, rx_exp.pop_front()});
    bus_read(A_CON, d);
    check_val("con_rx_clr", {31'h0, d[3]}, 32'h0);

    // Two bytes with RX interrupt, second held back until the first is read
    bus_write(A_CON, 32'h0000_0002);
    rc0 = rx_read_count;
    rx_exp.push_back(8'h01); rx_exp.push_back(8'h02);
    rx_src.push_back(8'h01); rx_src.push_back(8'h02);
    wait_irq("rx_irq1", 20);
    wait_cycles(4);
    check_val("rx_backpressure", rx_read_count - rc0, 32'd1);
    bus_read(A_RXD, d);
    check_val("rxd_01", d, {24'h0, rx_exp.pop_front()});
    check_val("rx_irq_drop", {31'h0, bus.irq}, 32'h0);
    wait_irq("rx_irq2", 20);
    bus_read(A_RXD, d);
    check_val("rxd_02", d, {24'h0, rx_exp.pop_front()});
    check_val("rx_irq_end", {31'h0, bus.irq}, 32'h0);
    check_val("rx_read_twice", rx_read_count - rc0, 32'd2);

    // Reset while waiting for a frame to finish with two bytes queued
    tx_exp.push_back(8'h61);
    burst_txd(8'h61, 3);
    wait_cycles(3);
    @(posedge sysclk); #1 reset = 1'b1;
    @(posedge sysclk); #1 reset = 1'b0;
    check_val("rst2_tx_en", {31'h0, bus.tx_en}, 32'h0);
    check_val("rst2_irq", {31'h0, bus.irq}, 32'h0);
    bus_read(A_CON, d);
    check_val("rst2_con", d, 32'h20);
    tc0 = tx_count;
    wait_cycles(30);
    check_val("rst2_no_tx", tx_count - tc0, 32'd0);
    tx_exp.push_back(8'h77);
    bus_write(A_TXD, 32'h0000_0077);
    wait_tx_drained("rst2_new_tx", 40);
    check_val("rst2_one_tx", tx_count - tc0, 32'd1);
    wait_tx_status_high("rst2_done_wait", 40);

    check_val("tx_exp_empty", tx_exp.size(), 32'h0);
    check_val("rx_exp_empty", rx_exp.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_bus_bridge.md
Name: uart_bus_bridge

Overview:
- CPU-side counterpart of the UART peripheral; drives the UART's parallel handshakes (TX_EN/TX_STATUS, RX_EFF/RX_READ).
- Presents three memory-mapped registers (TXD, RXD, CON) to the data-memory bus.
- Buffers outgoing bytes in a small FIFO and holds one received byte.
- Raises an interrupt on TX completion or RX availability.

Parameters:
- TX_DEPTH, 4, TX FIFO entries; power of 2, minimum 2.
- ADDR_TXD, 8'h18, byte-address offset of the TXD register.
- ADDR_RXD, 8'h1C, byte-address offset of the RXD register.
- ADDR_CON, 8'h20, byte-address offset of the CON register.

Ports:
- sysclk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- rd  in  1  bus read strobe.
- wr  in  1  bus write strobe.
- addr  in  8  byte-address offset within the peripheral space.
- wdata  in  32  bus write data.
- rdata  out  32  read data; combinational from addr and the registers.
- irq  out  1  level interrupt.
- uart_rxd  in  8  received byte from the UART.
- rx_eff  in  1  UART holds an unread byte.
- rx_read  out  1  one-cycle pulse: byte has been taken.
- uart_txd  out  8  byte to transmit.
- tx_en  out  1  one-cycle send request.
- tx_status  in  1  1 = UART sender idle.

Behaviour:
- Reset (reset=1 at an edge):
  - rx_read=0, tx_en=0, uart_txd=0.
  - FIFO empty; rx_hold=0, rx_valid=0.
  - CON bits cleared; TX FSM in IDLE; irq=0.
- TXD write (wr, addr==ADDR_TXD):
  - Not full: push wdata[7:0].
  - Full: byte dropped, tx_ovf sticky set.
- TX FSM:
  - IDLE: if FIFO non-empty and tx_status==1, then uart_txd<=head, tx_en<=1 for exactly one cycle, pop, go to WAIT_BUSY.
  - WAIT_BUSY: stay until tx_status==0, then go to WAIT_DONE.
  - WAIT_DONE: stay until tx_status==1, then set tx_done sticky and go to IDLE.
  - uart_txd stays stable from launch until the next launch.
- TX latency: TXD write at edge k into an idle, empty bridge gives tx_en high in the cycle after edge k+1.
- Push and launch-pop in the same cycle: both take effect; count unchanged.
- RX capture:
  - Capture when rx_eff==1, rx_valid==0 and rx_read==0: rx_hold<=uart_rxd, rx_valid<=1, rx_read<=1 for one cycle.
  - The rx_read==0 guard prevents a double capture while the UART is still clearing RX_EFF.
  - If rx_valid==1, no capture; the UART keeps rx_eff high (backpressure).
- RXD read (rd, addr==ADDR_RXD):
  - rdata={24'b0, rx_hold}; rx_valid cleared at the edge.
  - A capture in that same cycle is blocked; it occurs on a later cycle.
- CON register bits:
  - [0] tx_irq_en, R/W.
  - [1] rx_irq_en, R/W.
  - [2] tx_done, sticky; cleared by a CON read.
  - [3] rx_valid, RO.
  - [4] fifo_full, RO.
  - [5] tx_idle = FIFO empty and FSM in IDLE, RO.
  - [6] tx_ovf, sticky; cleared by a CON read.
  - [31:7] read as 0.
- CON write updates bits [1:0] only.
- A sticky set and a CON read in the same cycle: the set wins.
- irq = (tx_irq_en & tx_done) | (rx_irq_en & rx_valid).
- Unmapped read returns 0; unmapped write is ignored.
- rd and wr in the same cycle are both honoured.
- Reset mid-transfer:
  - The bridge returns to IDLE and the FIFO content is lost.
  - An already-launched UART frame completes on the line; the bridge ignores its tx_status transitions.

Decomposition:
- Package uart_bridge_pkg holds:
  - address offset defaults;
  - CON bit indices;
  - TX FSM state encoding (IDLE, WAIT_BUSY, WAIT_DONE).
- Sub-module uart_tx_fifo: synchronous FIFO, parameter DEPTH.
  - Ports push/din/pop/dout/full/empty.
  - Same-cycle push and pop allowed; dout is the head, valid whenever not empty.

Test Plan:
- Reset then a CON read -> rdata=32'h20 (tx_idle=1); irq=0, tx_en=0, rx_read=0.
- Write TXD=8'hA5 with tx_status=1 -> one-cycle tx_en, uart_txd=A5. Model drops tx_status for 10 cycles, then raises it -> CON[2]=1; a second CON read shows CON[2]=0.
- Five back-to-back TXD writes (11..15) with tx_status held 0 -> CON[4]=1, CON[6]=1. Release tx_status -> bytes 11,12,13,14 sent in order; 15 lost.
- uart_rxd=8'h3C with rx_eff=1; model clears rx_eff the cycle after rx_read -> exactly one rx_read pulse. RXD read returns 32'h3C; CON[3] cleared.
- rx_irq_en=1, then two bytes 01,02 arrive before any read -> irq=1. First RXD read returns 01 and irq drops; the next byte is captured one or more cycles later, irq rises again, and a read returns 02.
- Assert reset while the FSM is in WAIT_DONE with 2 bytes queued -> next cycle: FSM IDLE, CON=32'h20, no tx_en until a new TXD write.
